// File: rtl/dram_byte_write_ctrl.sv
// dram_byte_write_ctrl: read-merge-write controller for one way of the cache data RAM.
// Optional macro DRAM_FULL_WORD_BYPASS_EN: full-word write hits skip the read via a WR state.
module dram_byte_write_ctrl #(
  parameter int          AWIDTH    = 3,
  parameter int          DWIDTH    = 32,
  parameter logic [15:0] STAT_INIT = 16'h0000  // reset value of the write-hit counter
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_hit,
  input  logic [AWIDTH-1:0]     req_addr,
  input  logic [DWIDTH-1:0]     req_wdata,
  input  logic [DWIDTH/8-1:0]   req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DWIDTH-1:0]     resp_data,
  output logic                  resp_miss,
  output logic [AWIDTH-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DWIDTH-1:0]     ram_din,
  input  logic [DWIDTH-1:0]     ram_dout,
  output logic [15:0]           stat_wr_hits
);

  localparam int BWIDTH = DWIDTH / 8;

`ifdef DRAM_FULL_WORD_BYPASS_EN
  typedef enum logic [2:0] {IDLE, RD, MRG, RESP, WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD, MRG, RESP} state_t;
`endif

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [AWIDTH-1:0]   addr_reg;
  logic [DWIDTH-1:0]   wdata_reg;
  logic [BWIDTH-1:0]   be_reg;
  logic [DWIDTH-1:0]   resp_data_reg;
  logic                resp_miss_reg;
  logic [15:0]         stat_reg;
  logic [DWIDTH-1:0]   merged;
  logic                cnt_inc;
  logic                accept;
  logic                wr_hit;

  assign accept = req_valid && (state_reg == IDLE);
  assign wr_hit = we_reg && (be_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < BWIDTH; gi++) begin : g_lane
      assign merged[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8] : ram_dout[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ram_we     = 1'b0;
    ram_din    = '0;
    ram_addr   = addr_reg;
    cnt_inc    = 1'b0;
    case (state_reg)
      IDLE: begin
        ram_addr = '0;
        if (req_valid) begin
          if (!req_hit)
            state_next = RESP;
`ifdef DRAM_FULL_WORD_BYPASS_EN
          else if (req_we && (&req_be))
            state_next = WR;
`endif
          else
            state_next = RD;
        end
      end
      RD: state_next = MRG;
      MRG: begin
        // ram_dout now holds the word addressed during RD
        if (wr_hit) begin
          ram_we  = 1'b1;
          ram_din = merged;
          cnt_inc = 1'b1;
        end
        state_next = RESP;
      end
`ifdef DRAM_FULL_WORD_BYPASS_EN
      WR: begin
        ram_we     = 1'b1;
        ram_din    = wdata_reg;
        cnt_inc    = 1'b1;
        state_next = RESP;
      end
`endif
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      resp_data_reg <= '0;
      resp_miss_reg <= 1'b0;
      stat_reg      <= STAT_INIT;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg        <= req_we;
        addr_reg      <= req_addr;
        wdata_reg     <= req_wdata;
        be_reg        <= req_be;
        resp_data_reg <= '0;
        resp_miss_reg <= !req_hit;
      end
      if (state_reg == MRG)
        resp_data_reg <= wr_hit ? merged : ram_dout;
`ifdef DRAM_FULL_WORD_BYPASS_EN
      if (state_reg == WR)
        resp_data_reg <= wdata_reg;
`endif
      if (cnt_inc && (stat_reg != 16'hFFFF))
        stat_reg <= stat_reg + 16'd1;
    end
  end

  assign req_ready    = (state_reg == IDLE);
  assign resp_valid   = (state_reg == RESP);
  assign resp_data    = resp_data_reg;
  assign resp_miss    = resp_miss_reg;
  assign stat_wr_hits = stat_reg;

endmodule

// File: tb/tb_dram_byte_write_ctrl.sv
// Directed bench: two controllers (counter from 0 and from 0xFFFE) share stimulus,
// each driving its own behavioural synchronous-read RAM.
module tb_dram_byte_write_ctrl;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clock = 1'b0;
  logic reset_n;
  logic req_valid, req_we, req_hit, resp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;

  logic req_ready, resp_valid, resp_miss, ram_we;
  logic [DW-1:0] resp_data, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  logic [15:0] stat_wr_hits;

  logic s_req_ready, s_resp_valid, s_resp_miss, s_ram_we;
  logic [DW-1:0] s_resp_data, s_ram_din, s_ram_dout;
  logic [AW-1:0] s_ram_addr;
  logic [15:0] s_stat_wr_hits;

  logic [DW-1:0] mem [0:7];
  logic [DW-1:0] s_mem [0:7];

  int n_cmp = 0;
  int n_err = 0;
  int we_pulses = 0;
  int lat;
  int we_before;

  always #5 clock = ~clock;

  dram_byte_write_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_hit(req_hit),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_miss(resp_miss),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .stat_wr_hits(stat_wr_hits)
  );

  dram_byte_write_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .STAT_INIT(16'hFFFE)) u_sat (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we), .req_hit(req_hit),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_data(s_resp_data), .resp_miss(s_resp_miss),
    .ram_addr(s_ram_addr), .ram_we(s_ram_we), .ram_din(s_ram_din), .ram_dout(s_ram_dout),
    .stat_wr_hits(s_stat_wr_hits)
  );

  // Synchronous-read RAMs, read-before-write
  always @(posedge clock) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_din;
    if (ram_we === 1'b1) we_pulses++;
  end

  always @(posedge clock) begin
    s_ram_dout <= s_mem[s_ram_addr];
    if (s_ram_we) s_mem[s_ram_addr] = s_ram_din;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic hit, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be, output int l);
    req_valid = 1'b1; req_we = we; req_hit = hit; req_addr = a; req_wdata = d; req_be = be;
    @(negedge clock);
    req_valid = 1'b0;
    l = 1;
    while (!resp_valid && l < 10) begin
      @(negedge clock);
      l++;
    end
    $display("txn we=%0b hit=%0b addr=%0d be=%b wdata=%h -> lat=%0d data=%h miss=%0b stat=%h",
             we, hit, a, be, d, l, resp_data, resp_miss, stat_wr_hits);
  endtask

  task automatic chk_rsp(input string tag, input int l, input int exp_lat,
                         input logic [DW-1:0] exp_data, input logic exp_miss);
    chk({tag, "_lat"}, l, exp_lat);
    chk({tag, "_valid"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_miss"}, resp_miss, exp_miss);
    chk({tag, "_svalid"}, s_resp_valid, 1);
    chk({tag, "_sdata"}, s_resp_data, exp_data);
    chk({tag, "_smiss"}, s_resp_miss, exp_miss);
  endtask

  task automatic retire(input string tag);
    @(negedge clock);
    chk({tag, "_ready_after"}, req_ready, 1);
    chk({tag, "_valid_after"}, resp_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_hit = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[1] = 32'h12345678; mem[2] = 32'hCAFEF00D; mem[3] = 32'h11223344;
    mem[5] = 32'hDEADBEEF; mem[6] = 32'h55555555;
    for (int i = 0; i < 8; i++) s_mem[i] = mem[i];

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_miss", resp_miss, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_stat", stat_wr_hits, 0);
    chk("rst_sstat", s_stat_wr_hits, 16'hFFFE);
    chk("rst_sready", s_req_ready, 1);
    reset_n = 1'b1;
    @(negedge clock);

    // Partial write hit, traced cycle by cycle
    req_valid = 1'b1; req_we = 1'b1; req_hit = 1'b1; req_addr = 3'd3;
    req_wdata = 32'hAABBCCDD; req_be = 4'b0101;
    @(negedge clock);
    req_valid = 1'b0;
    chk("c1_req_ready", req_ready, 0);
    chk("c1_ram_addr", ram_addr, 3);
    chk("c1_ram_we", ram_we, 0);
    chk("c1_resp_valid", resp_valid, 0);
    @(negedge clock);
    chk("c2_ram_we", ram_we, 1);
    chk("c2_ram_din", ram_din, 32'h11BB33DD);
    chk("c2_ram_addr", ram_addr, 3);
    chk("c2_resp_valid", resp_valid, 0);
    @(negedge clock);
    chk_rsp("wr3", 3, 3, 32'h11BB33DD, 0);
    chk("wr3_stat", stat_wr_hits, 1);
    chk("wr3_sstat", s_stat_wr_hits, 16'hFFFF);
    chk("wr3_mem", mem[3], 32'h11BB33DD);
    $display("txn we=1 hit=1 addr=3 be=0101 wdata=aabbccdd -> data=%h stat=%h", resp_data, stat_wr_hits);
    retire("wr3");
    chk("wr3_idle_addr", ram_addr, 0);

    // Second write hit: counter saturates in the preloaded instance
    issue(1'b1, 1'b1, 3'd1, 32'h000000AA, 4'b0001, lat);
    chk_rsp("wr1", lat, 3, 32'h123456AA, 0);
    chk("wr1_stat", stat_wr_hits, 2);
    chk("wr1_sstat", s_stat_wr_hits, 16'hFFFF);
    retire("wr1");

    // Read hit: no RAM write
    we_before = we_pulses;
    issue(1'b0, 1'b1, 3'd5, 32'hFFFFFFFF, 4'b1111, lat);
    chk_rsp("rd5", lat, 3, 32'hDEADBEEF, 0);
    chk("rd5_we_pulses", we_pulses - we_before, 0);
    chk("rd5_stat", stat_wr_hits, 2);
    retire("rd5");

    // Write miss: immediate response, no RAM access
    we_before = we_pulses;
    issue(1'b1, 1'b0, 3'd2, 32'hFFFFFFFF, 4'b1111, lat);
    chk_rsp("wm2", lat, 1, 32'h0, 1);
    chk("wm2_we_pulses", we_pulses - we_before, 0);
    chk("wm2_mem", mem[2], 32'hCAFEF00D);
    chk("wm2_stat", stat_wr_hits, 2);
    retire("wm2");

    // Write hit with no byte enables: behaves as a read
    we_before = we_pulses;
    issue(1'b1, 1'b1, 3'd3, 32'hFFFFFFFF, 4'b0000, lat);
    chk_rsp("be0", lat, 3, 32'h11BB33DD, 0);
    chk("be0_we_pulses", we_pulses - we_before, 0);
    chk("be0_stat", stat_wr_hits, 2);
    retire("be0");

    // Full-word write hit
    issue(1'b1, 1'b1, 3'd4, 32'h0F0F0F0F, 4'b1111, lat);
`ifdef DRAM_FULL_WORD_BYPASS_EN
    chk_rsp("fw4", lat, 2, 32'h0F0F0F0F, 0);
`else
    chk_rsp("fw4", lat, 3, 32'h0F0F0F0F, 0);
`endif
    chk("fw4_mem", mem[4], 32'h0F0F0F0F);
    chk("fw4_stat", stat_wr_hits, 3);
    retire("fw4");

    // Back-pressure: response held, new requests ignored
    resp_ready = 1'b0;
    issue(1'b0, 1'b1, 3'd5, 32'h0, 4'b0000, lat);
    chk_rsp("stall", lat, 3, 32'hDEADBEEF, 0);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_hit = 1'b0; req_addr = 3'd2;
      req_wdata = 32'h01020304; req_be = 4'b1111;
      @(negedge clock);
      chk("stall_valid", resp_valid, 1);
      chk("stall_data", resp_data, 32'hDEADBEEF);
      chk("stall_miss", resp_miss, 0);
      chk("stall_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    retire("stall");
    @(negedge clock);
    chk("stall_no_accept", resp_valid, 0);

    // Reset asserted during MRG discards the write
    req_valid = 1'b1; req_we = 1'b1; req_hit = 1'b1; req_addr = 3'd6;
    req_wdata = 32'hAAAAAAAA; req_be = 4'b0011;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("mrg_we_before_rst", ram_we, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_ram_we", ram_we, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_ram_addr", ram_addr, 0);
    chk("arst_ram_din", ram_din, 0);
    chk("arst_resp_data", resp_data, 0);
    chk("arst_stat", stat_wr_hits, 0);
    @(negedge clock);
    chk("arst_mem", mem[6], 32'h55555555);
    reset_n = 1'b1;
    @(negedge clock);
    issue(1'b0, 1'b1, 3'd6, 32'h0, 4'b0000, lat);
    chk_rsp("rd6", lat, 3, 32'h55555555, 0);
    retire("rd6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
